// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage ahead of the single-cycle decode/control.
// Owns the PC and issues one instruction-memory request at a time. It holds the
// fetched word until downstream consumes it, then steps to pc+4 or to the
// redirect target chosen by pcsrc/jbmux. A target with bit 1 set parks the unit
// in a terminal fault state until reset. Consumed instructions are counted.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   imem_req_valid/ready, addr    request channel (addr always equals pc)
//   imem_rsp_valid, rsp_data      response channel (only honoured while waiting)
//   instr_valid/ready             handshake to the decode stage
//   instr, instr_pc, instr_pc_plus4  held instruction, its PC, and PC+4
//   pcsrc, jbmux, immext, aluresult  next-PC controls, sampled on consume
//   fault                         sticky misaligned-target flag
//   instret                       count of consumed instructions
module fetch_unit #(
   parameter int unsigned      AW       = 32,
   parameter logic [AW-1:0]    RESET_PC = 32'hBFC0_0000
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic          imem_req_valid,
   input  logic          imem_req_ready,
   output logic [AW-1:0] imem_addr,
   input  logic          imem_rsp_valid,
   input  logic [31:0]   imem_rsp_data,
   output logic          instr_valid,
   input  logic          instr_ready,
   output logic [31:0]   instr,
   output logic [AW-1:0] instr_pc,
   output logic [AW-1:0] instr_pc_plus4,
   input  logic          pcsrc,
   input  logic          jbmux,
   input  logic [AW-1:0] immext,
   input  logic [AW-1:0] aluresult,
   output logic          fault,
   output logic [31:0]   instret
);

   localparam logic [AW-1:0] PC_STEP  = AW'(4);
   localparam logic [AW-1:0] LSB_MASK = ~AW'(1);
   localparam logic [31:0]   NOP      = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_FAULT
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [AW-1:0] instr_pc_q, instr_pc_d;
   logic [31:0]   instr_q, instr_d;
   logic [31:0]   instret_q, instret_d;
   logic          instr_valid_q, instr_valid_d;
   logic          fault_q, fault_d;

   logic [AW-1:0] seq_pc;
   logic [AW-1:0] target_pc;
   logic [AW-1:0] next_pc;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_REQ;
         pc_q          <= RESET_PC;
         instr_pc_q    <= RESET_PC;
         instr_q       <= NOP;
         instret_q     <= '0;
         instr_valid_q <= 1'b0;
         fault_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_pc_q    <= instr_pc_d;
         instr_q       <= instr_d;
         instret_q     <= instret_d;
         instr_valid_q <= instr_valid_d;
         fault_q       <= fault_d;
      end
   end

   // Next-state and datapath
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_pc_d    = instr_pc_q;
      instr_d       = instr_q;
      instret_d     = instret_q;
      instr_valid_d = instr_valid_q;
      fault_d       = fault_q;

      seq_pc    = pc_q + PC_STEP;
      // JALR target drops bit 0 of rs1+imm; masking keeps every aluresult bit in use
      target_pc = jbmux ? (aluresult & LSB_MASK) : (instr_pc_q + immext);
      next_pc   = pcsrc ? target_pc : seq_pc;

      case (state_q)
         S_REQ: begin
            if (imem_req_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (imem_rsp_valid) begin
               instr_d       = imem_rsp_data;
               instr_pc_d    = pc_q;
               instr_valid_d = 1'b1;
               state_d       = S_HOLD;
            end
         end
         S_HOLD: begin
            if (instr_ready) begin
               instr_valid_d = 1'b0;
               if (next_pc[1]) begin
                  // Misaligned target: pc and instret keep their pre-fault values
                  fault_d = 1'b1;
                  state_d = S_FAULT;
               end else begin
                  pc_d      = next_pc;
                  instret_d = instret_q + 32'd1;
                  state_d   = S_REQ;
               end
            end
         end
         S_FAULT: begin
            state_d = S_FAULT;
         end
         default: begin
            state_d = S_FAULT;
         end
      endcase
   end

   // Outputs
   always_comb begin
      // Gated by rst_n so no request is presented during the reset cycle itself
      imem_req_valid = rst_n && (state_q == S_REQ);
      imem_addr      = pc_q;
      instr_valid    = instr_valid_q;
      instr          = instr_q;
      instr_pc       = instr_pc_q;
      instr_pc_plus4 = instr_pc_q + PC_STEP;
      fault          = fault_q;
      instret        = instret_q;
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a memory/consumer driver feeds randomized traffic and
// pushes every returned word into a scoreboard queue; an independent monitor
// tracks the expected fetch behaviour and compares DUT outputs each cycle.
module tb_fetch_unit;
   localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   typedef struct packed {
      logic        pcsrc;
      logic        jbmux;
      logic [31:0] imm;
      logic [31:0] alu;
   } ctrl_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [31:0] instr_pc_plus4;
   logic        pcsrc = 1'b0;
   logic        jbmux = 1'b0;
   logic [31:0] immext = '0;
   logic [31:0] aluresult = '0;
   logic        fault;
   logic [31:0] instret;

   always #5 clk = ~clk;

   fetch_unit #(
      .AW(32),
      .RESET_PC(RESET_PC)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .imem_req_valid(imem_req_valid),
      .imem_req_ready(imem_req_ready),
      .imem_addr(imem_addr),
      .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .instr(instr),
      .instr_pc(instr_pc),
      .instr_pc_plus4(instr_pc_plus4),
      .pcsrc(pcsrc),
      .jbmux(jbmux),
      .immext(immext),
      .aluresult(aluresult),
      .fault(fault),
      .instret(instret)
   );

   int checks = 0;
   int failures = 0;

   logic [31:0] rsp_q[$];   // words returned by memory, oldest first
   ctrl_t       ctrl_q[$];  // scripted next-PC controls, one per consume

   // Reference model state (monitor-owned)
   bit          m_req, m_wait, m_hold, m_fault, post_rst;
   logic [31:0] m_pc, m_instret, m_next;
   int          m_consumed;

   // Driver state
   bit directed, outstanding, rst_wait, first_data;
   int rsp_delay, req_stall, hold_stall, n_cons;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Monitor: samples mid-cycle, when inputs for the coming edge are stable
   always @(negedge clk) begin
      if (!rst_n) begin
         check("req_valid_in_reset", 32'(imem_req_valid), 32'd0);
         m_req      = 1'b1;
         m_wait     = 1'b0;
         m_hold     = 1'b0;
         m_fault    = 1'b0;
         m_pc       = RESET_PC;
         m_instret  = '0;
         m_consumed = 0;
         post_rst   = 1'b1;
         rsp_q.delete();
      end else begin
         if (post_rst) begin
            check("reset_instr", instr, NOP);
            check("reset_instr_pc", instr_pc, RESET_PC);
            post_rst = 1'b0;
         end
         check("req_valid", 32'(imem_req_valid), 32'(m_req));
         if (m_req) check("imem_addr", imem_addr, m_pc);
         check("instr_valid", 32'(instr_valid), 32'(m_hold));
         check("fault", 32'(fault), 32'(m_fault));
         check("instret", instret, m_instret);
         if (m_hold) begin
            if (rsp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL scoreboard_empty actual=%h required=<queued word>", instr);
            end else begin
               check("instr", instr, rsp_q[0]);
            end
            check("instr_pc", instr_pc, m_pc);
            check("instr_pc_plus4", instr_pc_plus4, m_pc + 32'd4);
         end

         if (m_req && imem_req_ready) begin
            m_req  = 1'b0;
            m_wait = 1'b1;
         end else if (m_wait && imem_rsp_valid) begin
            m_wait = 1'b0;
            m_hold = 1'b1;
         end else if (m_hold && instr_ready) begin
            m_hold = 1'b0;
            if (rsp_q.size() > 0) void'(rsp_q.pop_front());
            if (!pcsrc)     m_next = m_pc + 32'd4;
            else if (jbmux) m_next = aluresult & 32'hFFFF_FFFE;
            else            m_next = m_pc + immext;
            if (m_next[1]) begin
               m_fault = 1'b1;
            end else begin
               m_pc      = m_next;
               m_instret = m_instret + 32'd1;
               m_req     = 1'b1;
               m_consumed++;
            end
         end
      end
   end

   function automatic ctrl_t rand_ctrl();
      ctrl_t       c;
      logic [31:0] r;
      r       = $urandom;
      c.pcsrc = r[0];
      c.jbmux = r[1];
      c.imm   = {{20{r[13]}}, r[13:4], (r[19:16] == 4'd0), 1'b0};
      if (r[22:20] == 3'd0) c.alu = 32'hFFFF_FFFC;
      else c.alu = ($urandom & 32'hFFFF_FFFC) | {30'b0, (r[27:24] == 4'd0), r[28]};
      return c;
   endfunction

   task automatic apply_ctrl(input ctrl_t c);
      pcsrc     = c.pcsrc;
      jbmux     = c.jbmux;
      immext    = c.imm;
      aluresult = c.alu;
   endtask

   // Called 1 time unit after a rising edge; sets inputs for the next edge
   task automatic drive_cycle();
      ctrl_t c;
      if (!rst_n) begin
         rst_n = 1'b1;
         #1;
      end
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      instr_ready    = 1'b0;
      apply_ctrl(rand_ctrl());

      if (outstanding) begin
         if (rsp_delay > 0) begin
            rsp_delay--;
         end else begin
            outstanding    = 1'b0;
            imem_rsp_valid = 1'b1;
            if (rst_wait) begin
               rst_wait      = 1'b0;
               rst_n         = 1'b0;
               imem_rsp_data = 32'h1234_5678;
            end else begin
               if (first_data) begin
                  imem_rsp_data = 32'h0050_0093;
                  first_data    = 1'b0;
               end
               rsp_q.push_back(imem_rsp_data);
            end
         end
      end else if (directed ? instr_valid : ($urandom_range(0, 3) == 0)) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = 32'hDEAD_BEEF;
      end

      if (imem_req_valid) begin
         if (req_stall > 0) begin
            req_stall--;
         end else if (directed || $urandom_range(0, 2) != 0) begin
            imem_req_ready = 1'b1;
            outstanding    = 1'b1;
            rsp_delay      = directed ? 0 : int'($urandom_range(0, 3));
         end
      end else begin
         imem_req_ready = 1'($urandom_range(0, 1));
      end

      if (instr_valid) begin
         if (hold_stall > 0) begin
            hold_stall--;
         end else if (directed || $urandom_range(0, 1) == 1) begin
            instr_ready = 1'b1;
            if (ctrl_q.size() > 0) c = ctrl_q.pop_front();
            else c = rand_ctrl();
            apply_ctrl(c);
            n_cons++;
            if (directed && n_cons == 1) begin
               req_stall  = 4;
               hold_stall = 5;
            end
         end
      end else begin
         instr_ready = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      instr_ready    = 1'b0;
      outstanding    = 1'b0;
      req_stall      = 0;
      hold_stall     = 0;
      n_cons         = 0;
      ctrl_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         drive_cycle();
         @(posedge clk);
         #1;
      end
   endtask

   task automatic run_episode(input int target, input int limit);
      int cyc = 0;
      while (!m_fault && m_consumed < target && cyc < limit) begin
         drive_cycle();
         @(posedge clk);
         #1;
         cyc++;
      end
      if (cyc >= limit) begin
         checks++;
         failures++;
         $display("FAIL episode_timeout actual=%0d cycles required=<%0d", cyc, limit);
      end
   endtask

   function automatic ctrl_t mk(input logic p, input logic j, input logic [31:0] i, input logic [31:0] a);
      ctrl_t c;
      c.pcsrc = p;
      c.jbmux = j;
      c.imm   = i;
      c.alu   = a;
      return c;
   endfunction

   initial begin
      directed   = 1'b1;
      first_data = 1'b1;
      rst_wait   = 1'b0;
      do_reset();
      ctrl_q.push_back(mk(1'b0, 1'b0, 32'h0, 32'h0));           // 0000 -> 0004
      ctrl_q.push_back(mk(1'b0, 1'b0, 32'h0, 32'h0));           // 0004 -> 0008
      ctrl_q.push_back(mk(1'b0, 1'b0, 32'h0, 32'h0));           // 0008 -> 000C
      ctrl_q.push_back(mk(1'b0, 1'b0, 32'h0, 32'h0));           // 000C -> 0010
      ctrl_q.push_back(mk(1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0));   // branch 0010 -> 0008
      ctrl_q.push_back(mk(1'b1, 1'b1, 32'h0, 32'h0000_1235));   // JALR -> 1234
      ctrl_q.push_back(mk(1'b1, 1'b1, 32'h0, 32'hFFFF_FFFC));   // JALR -> FFFF_FFFC
      ctrl_q.push_back(mk(1'b0, 1'b0, 32'h0, 32'h0));           // wrap -> 0000_0000
      ctrl_q.push_back(mk(1'b1, 1'b1, 32'h0, 32'h0000_1236));   // misaligned -> fault
      run_episode(100, 2000);
      idle(10);

      directed = 1'b0;
      do_reset();
      rst_wait = 1'b1;
      run_episode(20, 3000);
      idle(5);

      for (int e = 0; e < 8; e++) begin
         do_reset();
         run_episode(40, 3000);
         idle(5);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
